wrr_arbiter: RTL and testbench

Parametrised weighted round-robin arbiter. It grants one of WIDTH requesters at a time and holds each grant for a per-channel programmable quantum. It also supports a fixed-priority mode, a lock input that extends the current grant, and status outputs (one-hot grant, binary grant index, expiry pulse). It sits in front of the coprocessor's shared execution resources and is the next generation of the single-quantum round-robin arbiter.

---
 rtl/wrr_arbiter_if.sv | 27 ++
 rtl/wrr_arbiter.sv | 108 ++++++++++
 tb/tb_wrr_arbiter.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/wrr_arbiter_if.sv
// Request/grant bundle for the weighted round-robin arbiter.
// The arbiter connects through the slave modport and the requester side through master.
interface wrr_arbiter_if #(
  parameter int WIDTH = 4,
  parameter int QW    = 4
);
  localparam int IDW = $clog2(WIDTH);

  logic [WIDTH-1:0]    in_request;
  logic [WIDTH*QW-1:0] in_quantum;
  logic                in_mode;
  logic                in_lock;
  logic [WIDTH-1:0]    out_grant;
  logic [IDW-1:0]      out_grant_id;
  logic                out_valid;
  logic                out_expired;

  modport slave (
    input  in_request, in_quantum, in_mode, in_lock,
    output out_grant, out_grant_id, out_valid, out_expired
  );

  modport master (
    output in_request, in_quantum, in_mode, in_lock,
    input  out_grant, out_grant_id, out_valid, out_expired
  );
endinterface

// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter: per-channel grant quantum, optional fixed priority,
// lock to extend a grant, and a one-cycle pulse when a grant expires on quantum.
module wrr_arbiter #(
  parameter int WIDTH = 4,
  parameter int QW    = 4,
  parameter int IDW   = $clog2(WIDTH)
) (
  input logic         in_clk,
  input logic         in_reset,
  wrr_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ARB, WORK} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] grant_q, grant_d;
  logic [IDW-1:0]   gid_q, gid_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [QW-1:0]    cnt_q, cnt_d;
  logic             exp_q, exp_d;

  logic             found;
  logic [IDW-1:0]   win;
  logic [QW-1:0]    q_win;
  int               idx;

  // Winner search: circular from the pointer in round robin, from index 0 in fixed priority.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 0; k < WIDTH; k++) begin
      idx = bus.in_mode ? k : (int'(ptr_q) + k) % WIDTH;
      if (!found && bus.in_request[idx[IDW-1:0]]) begin
        found = 1'b1;
        win   = idx[IDW-1:0];
      end
    end
    q_win = bus.in_quantum[win*QW +: QW];
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gid_d   = gid_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    exp_d   = 1'b0;
    case (state_q)
      IDLE: begin
        grant_d = '0;
        gid_d   = '0;
        if (|bus.in_request) state_d = ARB;
      end
      ARB: begin
        if (found) begin
          grant_d = WIDTH'(1) << win;
          gid_d   = win;
          cnt_d   = (q_win == '0) ? QW'(1) : q_win;
          state_d = WORK;
        end else begin
          state_d = IDLE;
        end
      end
      WORK: begin
        if (!bus.in_request[gid_q] || (cnt_q == QW'(1) && !bus.in_lock)) begin
          // Expiry pulse only when the quantum ran out, not when the requester let go.
          exp_d   = bus.in_request[gid_q];
          grant_d = '0;
          gid_d   = '0;
          ptr_d   = (gid_q == IDW'(WIDTH - 1)) ? '0 : gid_q + IDW'(1);
          state_d = (|bus.in_request) ? ARB : IDLE;
        end else if (cnt_q != QW'(1)) begin
          cnt_d = cnt_q - QW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        gid_d   = '0;
      end
    endcase
  end

  always_ff @(posedge in_clk or posedge in_reset) begin
    if (in_reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      gid_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      exp_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gid_q   <= gid_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      exp_q   <= exp_d;
    end
  end

  assign bus.out_grant    = grant_q;
  assign bus.out_grant_id = gid_q;
  assign bus.out_valid    = |grant_q;
  assign bus.out_expired  = exp_q;

endmodule

// File: tb/tb_wrr_arbiter.sv
// Bench for wrr_arbiter: an owner/cycles-left model checked every cycle,
// plus directed scenarios with hand-computed grant sequences.
module tb_wrr_arbiter;
  localparam int W  = 4;
  localparam int QW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  wrr_arbiter_if #(.WIDTH(W), .QW(QW)) bus ();
  wrr_arbiter #(.WIDTH(W), .QW(QW)) dut (.in_clk(clk), .in_reset(rst), .bus(bus));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: who owns the resource, how many grant cycles remain, and whether an arbitration is due.
  int m_owner = -1;
  int m_left  = 0;
  int m_ptr   = 0;
  int m_w     = -1;
  int m_idx   = 0;
  bit m_arb   = 1'b0;
  bit m_exp   = 1'b0;
  bit m_rel   = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_owner = -1; m_left = 0; m_ptr = 0; m_arb = 1'b0; m_exp = 1'b0;
    end else begin
      m_exp = 1'b0;
      m_rel = 1'b0;
      if (m_owner >= 0) begin
        if (!bus.in_request[m_owner]) m_rel = 1'b1;
        else if (m_left == 1) begin
          if (!bus.in_lock) begin m_rel = 1'b1; m_exp = 1'b1; end
        end else m_left = m_left - 1;
        if (m_rel) begin
          m_ptr   = (m_owner + 1) % W;
          m_owner = -1;
          m_arb   = (bus.in_request != 0);
        end
      end else if (m_arb) begin
        m_w = -1;
        for (int k = 0; k < W; k++) begin
          m_idx = bus.in_mode ? k : (m_ptr + k) % W;
          if (m_w < 0 && bus.in_request[m_idx]) m_w = m_idx;
        end
        if (m_w >= 0) begin
          m_owner = m_w;
          m_left  = int'(bus.in_quantum[m_w*QW +: QW]);
          if (m_left == 0) m_left = 1;
        end
        m_arb = 1'b0;
      end else begin
        m_arb = (bus.in_request != 0);
      end
    end
  end

  logic [W-1:0] e_grant;
  int           e_id;
  always @(negedge clk) begin
    e_grant = (m_owner >= 0) ? W'(1) << m_owner : '0;
    e_id    = (m_owner >= 0) ? m_owner : 0;
    checks++;
    if (bus.out_grant !== e_grant || int'(bus.out_grant_id) != e_id ||
        bus.out_valid !== (m_owner >= 0) || bus.out_expired !== m_exp) begin
      errors++;
      $display("FAIL model_cmp t=%0t got grant=%b id=%0d valid=%b exp=%b want grant=%b id=%0d valid=%b exp=%b",
               $time, bus.out_grant, bus.out_grant_id, bus.out_valid, bus.out_expired,
               e_grant, e_id, (m_owner >= 0), m_exp);
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s t=%0t got %0d want %0d", nm, $time, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_valid(input bit v, input string nm);
    int n;
    n = 0;
    while (bus.out_valid !== v && n < 20) begin
      tick(1);
      n++;
    end
    checks++;
    if (n >= 20) begin
      errors++;
      $display("FAIL %s timeout waiting for valid=%0d", nm, v);
    end
  endtask

  task automatic do_reset();
    bus.in_request = '0;
    bus.in_lock    = 1'b0;
    bus.in_mode    = 1'b0;
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
  endtask

  int e2g [16] = '{0, 1, 0, 2, 2, 0, 4, 4, 4, 0, 8, 8, 8, 8, 0, 1};
  int e2x [16] = '{0, 0, 1, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0};
  int e6g [8]  = '{0, 2, 0, 2, 0, 2, 0, 2};
  int e6x [8]  = '{0, 0, 1, 0, 1, 0, 1, 0};
  int n1, n3;

  initial begin
    bus.in_request = '0;
    bus.in_quantum = 16'h4321;
    bus.in_mode    = 1'b0;
    bus.in_lock    = 1'b0;
    tick(2);
    rst = 1'b0;

    // Async reset in the middle of a ch1 grant.
    bus.in_request = 4'b0010;
    tick(2);
    chk("t1_grant_ch1", int'(bus.out_grant), 2);
    chk("t1_id_ch1", int'(bus.out_grant_id), 1);
    #2 rst = 1'b1;
    #1;
    chk("t1_rst_grant", int'(bus.out_grant), 0);
    chk("t1_rst_valid", int'(bus.out_valid), 0);
    chk("t1_rst_id", int'(bus.out_grant_id), 0);
    tick(1);
    rst = 1'b0;
    bus.in_request = 4'b0001;
    tick(2);
    chk("t1_first_ch0", int'(bus.out_grant), 1);

    // Round robin, all requesting, quanta 1..4.
    do_reset();
    bus.in_quantum = 16'h4321;
    bus.in_request = 4'b1111;
    for (int i = 0; i < 16; i++) begin
      tick(1);
      chk("t2_grant_seq", int'(bus.out_grant), e2g[i]);
      chk("t2_expired_seq", int'(bus.out_expired), e2x[i]);
    end

    // Requester drops mid-grant: no expiry pulse.
    do_reset();
    bus.in_quantum = 16'h4844;
    bus.in_request = 4'b0100;
    tick(2);
    chk("t3_grant_ch2", int'(bus.out_grant), 4);
    tick(2);
    bus.in_request = '0;
    tick(1);
    chk("t3_released", int'(bus.out_grant), 0);
    chk("t3_no_expiry", int'(bus.out_expired), 0);
    tick(2);
    chk("t3_idle_valid", int'(bus.out_valid), 0);

    // Fixed priority starves ch3, then round robin serves it.
    do_reset();
    bus.in_quantum = 16'h2222;
    bus.in_mode    = 1'b1;
    bus.in_request = 4'b1010;
    n1 = 0; n3 = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (bus.out_grant == 4'b0010) n1++;
      if (bus.out_grant == 4'b1000) n3++;
    end
    chk("t4_ch3_starved", n3, 0);
    chk("t4_ch1_cycles", n1, 13);
    wait_valid(1'b1, "t4_wait_grant");
    bus.in_mode = 1'b0;
    wait_valid(1'b0, "t4_wait_release");
    wait_valid(1'b1, "t4_wait_next");
    chk("t4_ch3_after_switch", int'(bus.out_grant), 8);

    // Lock extends ch0 well past its quantum of 2.
    do_reset();
    bus.in_quantum = 16'h4442;
    bus.in_lock    = 1'b1;
    bus.in_request = 4'b0011;
    wait_valid(1'b1, "t5_wait_grant");
    chk("t5_grant_ch0", int'(bus.out_grant), 1);
    tick(5);
    chk("t5_held_ch0", int'(bus.out_grant), 1);
    bus.in_lock = 1'b0;
    wait_valid(1'b0, "t5_wait_release");
    chk("t5_expired", int'(bus.out_expired), 1);
    wait_valid(1'b1, "t5_wait_next");
    chk("t5_next_ch1", int'(bus.out_grant), 2);

    // Zero quantum behaves as one.
    do_reset();
    bus.in_quantum = 16'h4404;
    bus.in_request = 4'b0010;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      chk("t6_grant_seq", int'(bus.out_grant), e6g[i]);
      chk("t6_expired_seq", int'(bus.out_expired), e6x[i]);
    end

    bus.in_request = '0;
    tick(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
